pc_fetch_controller: RTL and testbench
======================================

Name: pc_fetch_controller

Overview:
Sequences the program counter and the instruction-memory fetch handshake for the core. Holds the architectural PC, issues one fetch per instruction to imem, and presents the fetched instruction to the datapath. Selects the next PC from sequential, branch, jump and trap sources. Replaces the free-running PC register update with a stall- and handshake-aware controller.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap_req or misaligned redirect

Ports:
clk  input  1  core clock, rising edge
reset_n  input  1  asynchronous, active-low reset
stall  input  1  datapath cannot consume the issued instruction this cycle
branch_taken  input  1  conditional branch resolved taken (valid in ISSUE only)
branch_target  input  32  branch destination
jump_en  input  1  unconditional jump (valid in ISSUE only)
jump_target  input  32  jump destination
trap_req  input  1  trap/exception request
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address (= pc_out)
imem_ack  input  1  imem_rdata valid, completes the request
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr is valid for the datapath
instr  output  32  registered instruction word
pc_out  output  32  PC of the current fetch/issue
misalign_fault  output  1  one-cycle pulse: redirect target not word aligned
instr_count  output  32  count of issued (consumed) instructions

Behaviour:
- Reset (reset_n low, async): state=BOOT, pc_out=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, misalign_fault=0, instr_count=0, trap_pending=0. Reset mid-fetch drops imem_req immediately; the in-flight ack is ignored.
- States: BOOT, FETCH, ISSUE.
- BOOT: one cycle after reset release, no request -> FETCH.
- FETCH: imem_req=1, imem_addr=pc_out. Address held stable while imem_req is high. On imem_ack: instr<=imem_rdata -> ISSUE. Ack may arrive in the first FETCH cycle (min fetch latency 1 cycle) or any later cycle. imem_ack outside FETCH is ignored.
- trap_req in FETCH: sets trap_pending. The handshake completes normally, then the fetched word is discarded (no ISSUE, instr_valid stays 0), pc_out<=TRAP_VECTOR, trap_pending cleared, stay in FETCH (new request next cycle).
- ISSUE: instr_valid=1. While stall=1: stay in ISSUE; instr, pc_out and instr_valid are held; redirect inputs ignored; trap_req is still taken (see priority).
- ISSUE exit (stall=0, or trap): instr_valid goes 0 next cycle. pc_out is updated, state -> FETCH.
- Next-PC priority: trap_req (or trap_pending) > jump_en > branch_taken > pc_out+4.
- trap in ISSUE overrides stall. The instruction is not counted.
- pc_out+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Misalignment: selected jump/branch target[1:0]!=0 -> pc_out<=TRAP_VECTOR, misalign_fault=1 for exactly one cycle (registered, coincident with the first FETCH of TRAP_VECTOR).
- instr_count increments by 1 on each ISSUE exit with stall=0 and no trap. A misaligned redirect still counts. Wraps modulo 2^32.
- Throughput: with 1-cycle ack and no stall, one instruction every 2 cycles (FETCH, ISSUE).

Test Plan:
- Reset release, imem acks every 1st FETCH cycle, no redirects -> imem_addr sequence 0x0,0x4,0x8; instr_valid pulses every 2nd cycle; instr_count=3 after 3 issues.
- Ack delayed 3 cycles at pc=0x8 -> imem_req high and imem_addr=0x8 stable for 3 cycles; instr_valid only after ack.
- stall=1 for 4 cycles in ISSUE with branch_taken=1, target 0x40 asserted during stall, deasserted at release -> pc held; next fetch 0x(pc+4), not 0x40; count +1 only at release.
- ISSUE with jump_en=1 to 0x200 and branch_taken=1 to 0x300 -> next imem_addr=0x200. Jump to 0x202 -> next imem_addr=0x100, misalign_fault pulses 1 cycle.
- trap_req in FETCH at pc=0x10 with ack 2 cycles later -> no instr_valid for that word; next imem_addr=0x100; instr_count unchanged.
- Force pc=0xFFFF_FFFC, sequential issue -> next imem_addr=0x0. Assert reset_n=0 mid-FETCH -> imem_req=0 immediately; after release, fetch restarts at RESET_VECTOR after one BOOT cycle.

Source files
------------

// File: rtl/pc_fetch_controller.sv
// PC sequencer and imem fetch handshake: BOOT -> FETCH -> ISSUE, with next-PC
// selection from sequential, branch, jump and trap sources.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        misalign_fault,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ISSUE} state_t;

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, w_next_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic        r_trap_pending, w_next_trap_pending;
  logic        r_misalign, w_next_misalign;
  logic        w_load_instr;
  logic        w_count_en;

  logic        w_redir_en;
  logic [31:0] w_redir_tgt;
  logic        w_redir_misal;
  logic [31:0] w_seq_pc;

  // Jump wins over branch; alignment is judged only on the selected target.
  assign w_redir_en    = jump_en | branch_taken;
  assign w_redir_tgt   = jump_en ? jump_target : branch_target;
  assign w_redir_misal = w_redir_en & (|w_redir_tgt[1:0]);
  assign w_seq_pc      = r_pc + 32'd4;

  always_comb begin
    w_next_state        = r_state;
    w_next_pc           = r_pc;
    w_next_trap_pending = r_trap_pending;
    w_next_misalign     = 1'b0;
    w_load_instr        = 1'b0;
    w_count_en          = 1'b0;
    case (r_state)
      S_BOOT: w_next_state = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          // A trap seen at any point of the handshake discards the fetched word.
          if (trap_req || r_trap_pending) begin
            w_next_pc           = TRAP_VECTOR;
            w_next_trap_pending = 1'b0;
          end else begin
            w_load_instr = 1'b1;
            w_next_state = S_ISSUE;
          end
        end else if (trap_req) begin
          w_next_trap_pending = 1'b1;
        end
      end
      S_ISSUE: begin
        if (trap_req) begin
          w_next_pc    = TRAP_VECTOR;
          w_next_state = S_FETCH;
        end else if (!stall) begin
          w_count_en   = 1'b1;
          w_next_state = S_FETCH;
          if (w_redir_misal) begin
            w_next_pc       = TRAP_VECTOR;
            w_next_misalign = 1'b1;
          end else if (w_redir_en) begin
            w_next_pc = w_redir_tgt;
          end else begin
            w_next_pc = w_seq_pc;
          end
        end
      end
      default: w_next_state = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_BOOT;
      r_pc           <= RESET_VECTOR;
      r_instr        <= 32'd0;
      r_count        <= 32'd0;
      r_trap_pending <= 1'b0;
      r_misalign     <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_pc           <= w_next_pc;
      r_trap_pending <= w_next_trap_pending;
      r_misalign     <= w_next_misalign;
      if (w_load_instr) r_instr <= imem_rdata;
      if (w_count_en)   r_count <= r_count + 32'd1;
    end
  end

  // Request and valid decode straight from state so reset drops them at once.
  assign imem_req       = (r_state == S_FETCH);
  assign imem_addr      = r_pc;
  assign instr_valid    = (r_state == S_ISSUE);
  assign instr          = r_instr;
  assign pc_out         = r_pc;
  assign misalign_fault = r_misalign;
  assign instr_count    = r_count;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed plan scenarios plus randomized
// instruction streams checked against a per-instruction PC/count model.
module tb_pc_fetch_controller;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        trap_req = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        misalign_fault;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Model: architectural PC of the pending fetch and number of consumed instructions.
  logic [31:0] m_pc;
  logic [31:0] m_count;

  pc_fetch_controller #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_en(jump_en), .jump_target(jump_target), .trap_req(trap_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .pc_out(pc_out), .misalign_fault(misalign_fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump_en = 1'b0; trap_req = 1'b0;
    imem_ack = 1'b0;
  endtask

  // Starts in the first FETCH cycle; leaves the DUT in the following FETCH cycle.
  task automatic do_instr(input string nm, input int lat, input int stl,
                          input bit jmp, input logic [31:0] jt,
                          input bit br, input logic [31:0] bt, input bit trp);
    logic [31:0] word;
    logic [31:0] sel;
    bit          exp_fault;
    word = $urandom;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      errors++;
      $display("FAIL %s fetch_start req=%b addr=%h expected req=1 addr=%h", nm, imem_req, imem_addr, m_pc);
    end
    for (int i = 1; i < lat; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s fetch_wait%0d req=%b addr=%h vld=%b expected 1 %h 0", nm, i, imem_req, imem_addr, instr_valid, m_pc);
      end
    end
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    checks++;
    if (instr_valid !== 1'b1 || instr !== word || pc_out !== m_pc ||
        imem_req !== 1'b0 || misalign_fault !== 1'b0) begin
      errors++;
      $display("FAIL %s issue vld=%b instr=%h pc=%h req=%b flt=%b expected 1 %h %h 0 0",
               nm, instr_valid, instr, pc_out, imem_req, misalign_fault, word, m_pc);
    end
    for (int i = 0; i < stl; i++) begin
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
      jump_en = (i == 1); jump_target = 32'h0000_0802;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== word || pc_out !== m_pc || instr_count !== m_count) begin
        errors++;
        $display("FAIL %s stall%0d vld=%b instr=%h pc=%h cnt=%0d expected 1 %h %h %0d",
                 nm, i, instr_valid, instr, pc_out, instr_count, word, m_pc, m_count);
      end
    end
    stall = 1'b0;
    jump_en = jmp; jump_target = jt; branch_taken = br; branch_target = bt;
    trap_req = trp;
    if (trp) stall = $urandom_range(0, 1);
    tick();
    clear_inputs();
    exp_fault = 1'b0;
    if (trp) begin
      m_pc = TV;
    end else begin
      m_count = m_count + 1;
      if (jmp || br) begin
        sel = jmp ? jt : bt;
        if (sel[1:0] != 2'b00) begin
          m_pc = TV; exp_fault = 1'b1;
        end else begin
          m_pc = sel;
        end
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== m_pc ||
        misalign_fault !== exp_fault || instr_count !== m_count) begin
      errors++;
      $display("FAIL %s exit vld=%b req=%b addr=%h flt=%b cnt=%0d expected 0 1 %h %b %0d",
               nm, instr_valid, imem_req, imem_addr, misalign_fault, instr_count, m_pc, exp_fault, m_count);
    end
  endtask

  // trap_req pulses in the first FETCH cycle; ack arrives lat cycles in.
  task automatic trap_fetch(input string nm, input int lat);
    trap_req = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      imem_ack = (i == lat); imem_rdata = $urandom;
      tick();
      trap_req = 1'b0; imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL %s trap_fetch%0d vld=%b req=%b expected 0 1", nm, i, instr_valid, imem_req);
      end
    end
    m_pc = TV;
    checks++;
    if (imem_addr !== m_pc || instr_count !== m_count) begin
      errors++;
      $display("FAIL %s trap_redirect addr=%h cnt=%0d expected %h %0d", nm, imem_addr, instr_count, m_pc, m_count);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #13;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== RV || instr !== 32'd0 ||
        misalign_fault !== 1'b0 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset req=%b vld=%b pc=%h instr=%h flt=%b cnt=%0d expected 0 0 %h 0 0 0",
               imem_req, instr_valid, pc_out, instr, misalign_fault, instr_count, RV);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req req=%b expected 0", imem_req);
    end
    tick();
    m_pc = RV; m_count = 0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) do_instr("seq", 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (instr_count !== 32'd3) begin
      errors++;
      $display("FAIL seq_count cnt=%0d expected 3", instr_count);
    end
  endtask

  task automatic test_delayed_ack();
    do_instr("delay_ack", 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall_redirect();
    do_instr("stall_br", 1, 4, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jump_priority();
    do_instr("jmp_over_br", 1, 0, 1, 32'h200, 1, 32'h300, 0);
    do_instr("jmp_misalign", 2, 0, 1, 32'h202, 0, 0, 0);
    do_instr("br_misalign", 1, 1, 0, 0, 1, 32'h0000_0333, 0);
    do_instr("jmp_al_br_mis", 1, 0, 1, 32'h0000_0010, 1, 32'h0000_0003, 0);
  endtask

  task automatic test_trap();
    trap_fetch("trap_fetch_10", 2);
    do_instr("after_trap", 1, 0, 0, 0, 0, 0, 0);
    trap_fetch("trap_fetch_lat1", 1);
    do_instr("trap_issue", 1, 2, 0, 0, 1, 32'h40, 1);
  endtask

  task automatic test_wrap();
    do_instr("to_top", 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    do_instr("wrap", 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midfetch();
    imem_ack = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    imem_ack = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc_out !== RV || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_midfetch req=%b pc=%h cnt=%0d expected 0 %h 0", imem_req, pc_out, instr_count, RV);
    end
    tick();
    imem_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reboot_boot req=%b vld=%b expected 0 0", imem_req, instr_valid);
    end
    tick();
    m_pc = RV; m_count = 0;
    do_instr("restart", 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] t1, t2;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 7);
      t1 = $urandom & 32'hFFFF_FFFC;
      t2 = $urandom & 32'hFFFF_FFFC;
      case (kind)
        0: do_instr("rnd_seq", $urandom_range(1, 4), $urandom_range(0, 3), 0, t1, 0, t2, 0);
        1: do_instr("rnd_br", $urandom_range(1, 4), $urandom_range(0, 3), 0, t1, 1, t2, 0);
        2: do_instr("rnd_jmp", $urandom_range(1, 4), $urandom_range(0, 3), 1, t1, 0, t2, 0);
        3: do_instr("rnd_both", $urandom_range(1, 4), $urandom_range(0, 3), 1, t1, 1, t2 | 32'd1, 0);
        4: do_instr("rnd_jmis", $urandom_range(1, 4), $urandom_range(0, 3), 1, t1 | $urandom_range(1, 3), 0, t2, 0);
        5: do_instr("rnd_bmis", $urandom_range(1, 4), $urandom_range(0, 3), 0, t1, 1, t2 | $urandom_range(1, 3), 0);
        6: do_instr("rnd_trap", $urandom_range(1, 4), $urandom_range(0, 3), 1, t1, 1, t2, 1);
        default: trap_fetch("rnd_ftrap", $urandom_range(1, 4));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_delayed_ack();
    test_stall_redirect();
    test_jump_priority();
    test_trap();
    test_wrap();
    test_random();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
